n_pulse_sequencer: RTL

Parametrised successor to the fixed three-pulse generator. It produces a programmable train of `N_PULSES` RF pulses, each with its own delay, length and TX phase, followed by a programmable ADC acquisition window. The whole sequence can repeat a programmable number of times. It sits between the register/config interface, which supplies the flattened timing word, and the DDS phase mux, RF amplifier gate and ADC capture logic.

---
 rtl/n_pulse_sequencer.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/n_pulse_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : n_pulse_sequencer
//  Description : Programmable N-pulse RF sequencer. Each pulse slot has its
//                own delay, length and TX phase. The pulse train is followed
//                by an ADC acquisition window, and the whole sequence repeats
//                a programmable number of times. Any segment whose duration
//                is zero is skipped without consuming a cycle.
//  Ports       : clk, rst (sync, active-high)
//                start             - sequence request (accepted in IDLE only)
//                pulse_timing_data - flattened slot + global timing word
//                RF_signal_valid   - DDS valid; loss while running aborts
//                TX_active / TX_active_phase - pulse gate and its phase
//                amp_enable        - amplifier gate, leads each pulse
//                ADC_enable        - acquisition window
//                busy / done / abort - status and single-cycle strobes
//  Revision    : 1.0 - initial release
// ============================================================================
module n_pulse_sequencer #(
    parameter int            N_PULSES = 3,
    parameter int            TW       = 32,
    parameter int            PHASE_W  = 2,
    parameter logic [TW-1:0] AMP_LEAD = TW'(8)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [N_PULSES*(2*TW+PHASE_W)+3*TW-1:0] pulse_timing_data,
    input  logic                                    RF_signal_valid,
    output logic                                    TX_active,
    output logic [PHASE_W-1:0]                      TX_active_phase,
    output logic                                    amp_enable,
    output logic                                    ADC_enable,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    abort
);

    localparam int c_slot_w     = 2*TW + PHASE_W;
    localparam int c_glob       = N_PULSES * c_slot_w;
    localparam int c_cfg_w      = c_glob + 3*TW;
    // Segments in order: DELAY(0), PULSE(0), ..., DELAY(N-1), PULSE(N-1),
    // ACQ_DELAY, ACQ. Segment index 2i is DELAY(i), 2i+1 is PULSE(i).
    localparam int c_nseg       = 2*N_PULSES + 2;
    localparam int c_seg_w      = $clog2(c_nseg + 1);
    localparam int c_idx_w      = (N_PULSES > 1) ? $clog2(N_PULSES) : 1;
    localparam int c_last_pulse = 2*N_PULSES - 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DELAY     = 3'd1,
        PULSE     = 3'd2,
        ACQ_DELAY = 3'd3,
        ACQ       = 3'd4
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_idx_w-1:0]   r_slot, w_slot_nxt;
    logic [TW-1:0]        r_cnt, w_cnt_nxt;
    logic [TW-1:0]        r_rep, w_rep_nxt;
    logic [c_cfg_w-1:0]   r_cfg;
    logic                 w_load;

    logic                 r_tx, r_amp, r_adc, r_busy, r_done, r_abort;
    logic [PHASE_W-1:0]   r_phase, w_phase_nxt;
    logic                 w_tx_nxt, w_amp_nxt, w_adc_nxt, w_busy_nxt;
    logic                 w_done_nxt, w_abort_nxt;

    // Decoded configuration (live input while idle, shadow while running)
    logic [c_cfg_w-1:0]   w_cfg;
    logic [TW-1:0]        w_dur [c_nseg];
    logic [PHASE_W-1:0]   w_ph  [N_PULSES];
    logic [c_nseg-1:0]    w_nz;
    logic [TW-1:0]        w_reps;

    // Segment search
    logic [c_seg_w-1:0]   w_cur, w_lo, w_fwd_idx, w_wrap_idx, w_tgt;
    logic                 w_fwd_hit, w_wrap_hit;
    logic                 w_enter, w_wrap, w_finish, w_tail_passed;
    int                   w_ps;

    always_comb begin
        w_cfg = (r_state == IDLE) ? pulse_timing_data : r_cfg;
        for (int i = 0; i < N_PULSES; i++) begin
            w_dur[2*i]   = w_cfg[i*c_slot_w        +: TW];
            w_dur[2*i+1] = w_cfg[i*c_slot_w + TW   +: TW];
            w_ph[i]      = w_cfg[i*c_slot_w + 2*TW +: PHASE_W];
        end
        w_dur[c_nseg-2] = w_cfg[c_glob      +: TW];
        w_dur[c_nseg-1] = w_cfg[c_glob + TW +: TW];
        // rep_count of zero runs the sequence once
        w_reps = (w_cfg[c_glob + 2*TW +: TW] == '0) ? TW'(1)
                                                    : w_cfg[c_glob + 2*TW +: TW];
        for (int s = 0; s < c_nseg; s++) begin
            w_nz[s] = |w_dur[s];
        end
    end

    // Locate the next non-empty segment: forward from the one after the
    // current segment, and (for a new repetition) from the very beginning.
    always_comb begin
        case (r_state)
            DELAY:     w_cur = c_seg_w'(2*int'(r_slot));
            PULSE:     w_cur = c_seg_w'(2*int'(r_slot) + 1);
            ACQ_DELAY: w_cur = c_seg_w'(c_nseg - 2);
            ACQ:       w_cur = c_seg_w'(c_nseg - 1);
            default:   w_cur = '0;
        endcase
        w_lo       = (r_state == IDLE) ? '0 : w_cur + c_seg_w'(1);
        w_fwd_hit  = 1'b0;
        w_fwd_idx  = '0;
        w_wrap_hit = 1'b0;
        w_wrap_idx = '0;
        for (int s = c_nseg-1; s >= 0; s--) begin
            if (w_nz[s]) begin
                w_wrap_hit = 1'b1;
                w_wrap_idx = c_seg_w'(s);
                if (s >= int'(w_lo)) begin
                    w_fwd_hit = 1'b1;
                    w_fwd_idx = c_seg_w'(s);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_cnt_nxt   = r_cnt;
        w_rep_nxt   = r_rep;
        w_phase_nxt = r_phase;
        w_done_nxt  = 1'b0;
        w_abort_nxt = 1'b0;
        w_load      = 1'b0;
        w_tgt       = w_fwd_idx;
        w_enter     = 1'b0;
        w_wrap      = 1'b0;
        w_finish    = 1'b0;
        w_ps        = 0;
        // True when the final pulse slot lies after the current position,
        // i.e. it is passed over when the sequence ends or wraps.
        w_tail_passed = (r_state == IDLE) || (int'(w_cur) < c_last_pulse);

        if (r_state == IDLE) begin
            if (start && RF_signal_valid) begin
                w_load    = 1'b1;
                w_rep_nxt = TW'(1);
                if (w_fwd_hit) begin
                    w_enter = 1'b1;
                end else begin
                    w_finish = 1'b1;
                end
            end
        end else if (!RF_signal_valid) begin
            w_state_nxt = IDLE;
            w_abort_nxt = 1'b1;
        end else if (r_cnt != TW'(1)) begin
            w_cnt_nxt = r_cnt - TW'(1);
        end else if (w_fwd_hit) begin
            w_enter = 1'b1;
        end else if (r_rep < w_reps) begin
            w_rep_nxt = r_rep + TW'(1);
            w_tgt     = w_wrap_idx;
            w_enter   = 1'b1;
            w_wrap    = 1'b1;
        end else begin
            w_finish = 1'b1;
        end

        if (w_finish) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
            if (w_tail_passed) begin
                w_phase_nxt = w_ph[N_PULSES-1];
            end
        end

        if (w_enter) begin
            for (int s = 0; s < c_nseg; s++) begin
                if (int'(w_tgt) == s) begin
                    w_cnt_nxt = w_dur[s];
                end
            end
            if (int'(w_tgt) < 2*N_PULSES) begin
                w_state_nxt = w_tgt[0] ? PULSE : DELAY;
                w_slot_nxt  = c_idx_w'(w_tgt >> 1);
            end else if (int'(w_tgt) == c_nseg - 2) begin
                w_state_nxt = ACQ_DELAY;
            end else begin
                w_state_nxt = ACQ;
            end

            // The phase follows the latest pulse slot reached, including
            // zero-length slots skipped on the way to the target.
            if (w_tgt != '0) begin
                w_ps = (int'(w_tgt) - 1) >> 1;
                if (w_ps > N_PULSES - 1) begin
                    w_ps = N_PULSES - 1;
                end
                if ((r_state == IDLE) || w_wrap || (2*w_ps + 1 > int'(w_cur))) begin
                    for (int j = 0; j < N_PULSES; j++) begin
                        if (j == w_ps) begin
                            w_phase_nxt = w_ph[j];
                        end
                    end
                end
            end else if (w_wrap && w_tail_passed) begin
                w_phase_nxt = w_ph[N_PULSES-1];
            end
        end

        w_tx_nxt   = (w_state_nxt == PULSE);
        w_amp_nxt  = (w_state_nxt == PULSE) ||
                     ((w_state_nxt == DELAY) && (w_cnt_nxt <= AMP_LEAD));
        w_adc_nxt  = (w_state_nxt == ACQ);
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_slot  <= '0;
            r_cnt   <= '0;
            r_rep   <= '0;
            r_cfg   <= '0;
            r_tx    <= 1'b0;
            r_phase <= '0;
            r_amp   <= 1'b0;
            r_adc   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rep   <= w_rep_nxt;
            if (w_load) begin
                r_cfg <= pulse_timing_data;
            end
            r_tx    <= w_tx_nxt;
            r_phase <= w_phase_nxt;
            r_amp   <= w_amp_nxt;
            r_adc   <= w_adc_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    assign TX_active       = r_tx;
    assign TX_active_phase = r_phase;
    assign amp_enable      = r_amp;
    assign ADC_enable      = r_adc;
    assign busy            = r_busy;
    assign done            = r_done;
    assign abort           = r_abort;

endmodule
`default_nettype wire
